// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - byte stream, memory write port and status bundle of the boot loader
interface boot_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_wr;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_addr, mem_datain, mem_wr,
        input  cpu_hold, busy, done, error
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_addr, mem_datain, mem_wr,
        output cpu_hold, busy, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - receives a program image byte stream, writes it to memory, then releases the CPU
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 56,
    parameter int          TIMEOUT   = 1000
) (
    input  logic         clk,
    input  logic         rst,
    boot_loader_if.slave bus
);
    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [15:0] W_MAX   = 16'(MAX_WORDS);
    localparam logic [TW-1:0] W_TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t        r_state;
    logic [15:0]   r_n;
    logic [15:0]   r_words;
    logic [1:0]    r_idx;
    logic [23:0]   r_word;
    logic [7:0]    r_csum;
    logic [TW-1:0] r_tmo;
    logic          r_byte_ready;
    logic          r_mem_wr;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_datain;
    logic          r_cpu_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_accept;
    logic [15:0]   w_n_full;
    logic          w_waiting;

    assign w_accept  = bus.byte_valid && r_byte_ready;
    assign w_n_full  = {r_n[15:8], bus.byte_data};
    assign w_waiting = (r_state == S_HDR1) || (r_state == S_DATA) || (r_state == S_CHK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_HDR0;
            r_n          <= '0;
            r_words      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_tmo        <= '0;
            r_byte_ready <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_datain <= '0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_wr <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    // ready is held low only for the first cycle out of reset
                    r_byte_ready <= 1'b1;
                    if (w_accept) begin
                        r_n[15:8] <= bus.byte_data;
                        r_busy    <= 1'b1;
                        r_state   <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (w_accept) begin
                        r_tmo    <= '0;
                        r_n[7:0] <= bus.byte_data;
                        if (w_n_full > W_MAX) begin
                            r_state      <= S_ERR;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_error      <= 1'b1;
                        end else if (w_n_full == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_tmo  <= '0;
                        r_idx  <= r_idx + 2'd1;
                        r_word <= {r_word[15:0], bus.byte_data};
                        r_csum <= r_csum ^ bus.byte_data;
                        if (r_idx == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_mem_wr     <= 1'b1;
                            r_mem_datain <= {r_word, bus.byte_data};
                        end
                    end
                end
                S_WRITE: begin
                    r_tmo        <= '0;
                    r_mem_addr   <= r_mem_addr + 32'd4;
                    r_words      <= r_words + 16'd1;
                    r_byte_ready <= 1'b1;
                    r_state      <= (r_words + 16'd1 == r_n) ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (w_accept) begin
                        r_tmo        <= '0;
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        if (bus.byte_data == r_csum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_DONE: r_byte_ready <= 1'b0;
                S_ERR:  r_byte_ready <= 1'b0;
                default: begin
                    r_state      <= S_ERR;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_error      <= 1'b1;
                end
            endcase

            // idle watchdog; overrides the case only when nothing was accepted
            if (w_waiting && !w_accept) begin
                if (r_tmo == W_TLAST) begin
                    r_state      <= S_ERR;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                    r_error      <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_datain = r_mem_datain;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   low_cnt = 0;
    bit   tog = 1'b0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    boot_loader_if bus();

    boot_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(56), .TIMEOUT(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_datain);
        end
        if (bus.busy === 1'b1 && bus.byte_ready === 1'b0) low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit thr);
        bit got = 1'b0;
        bus.byte_data = b;
        for (int n = 0; n < 64 && !got; n++) begin
            bus.byte_valid = thr ? tog : 1'b1;
            tog = ~tog;
            got = bus.byte_valid && bus.byte_ready;
            @(negedge clk);
        end
        chk("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic check_status(input string tag, input logic hold, input logic bsy,
                                input logic dn, input logic er, input logic rdy);
        chk({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'(hold));
        chk({tag, "_busy"},       32'(bus.busy),       32'(bsy));
        chk({tag, "_done"},       32'(bus.done),       32'(dn));
        chk({tag, "_error"},      32'(bus.error),      32'(er));
        chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'(rdy));
    endtask

    // asserts reset mid-cycle, checks outputs drop immediately, then releases on a falling edge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_status(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wr"},   32'(bus.mem_wr), 32'd0);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wa.delete();
        wd.delete();
    endtask

    // N=2 image; payload XOR 20^08^00^05^AC^08^00^10 = 0x99
    task automatic load_image(input string tag, input bit thr, input logic [7:0] cs);
        logic [7:0] pl [8];
        pl = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h10};
        send_byte(8'h00, thr);
        chk({tag, "_busy_hdr"}, 32'(bus.busy), 32'd1);
        send_byte(8'h02, thr);
        for (int i = 0; i < 8; i++) begin
            send_byte(pl[i], thr);
            if (i == 3 || i == 7) begin
                chk({tag, "_wr_latency"}, 32'(bus.mem_wr), 32'd1);
                chk({tag, "_wr_ready"},   32'(bus.byte_ready), 32'd0);
            end
        end
        send_byte(cs, thr);
        bus.byte_valid = 1'b0;
        chk({tag, "_nwrites"}, 32'(wa.size()), 32'd2);
        chk({tag, "_addr0"}, qget(wa, 0), 32'h0000_0000);
        chk({tag, "_data0"}, qget(wd, 0), 32'h2008_0005);
        chk({tag, "_addr1"}, qget(wa, 1), 32'h0000_0004);
        chk({tag, "_data1"}, qget(wd, 1), 32'hAC08_0010);
        chk({tag, "_addr_hold"}, bus.mem_addr, 32'h0000_0008);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_status("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mem_wr",     32'(bus.mem_wr), 32'd0);
        chk("rst_mem_addr",   bus.mem_addr,    32'd0);
        chk("rst_mem_datain", bus.mem_datain,  32'd0);
        rst = 1'b1;
        chk("rel_ready_low", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_high", 32'(bus.byte_ready), 32'd1);

        load_image("nom", 1'b0, 8'h99);
        check_status("nom_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        do_reset("r1");
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        bus.byte_valid = 1'b0;
        chk("empty_nwrites", 32'(wa.size()), 32'd0);
        check_status("empty_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        do_reset("r2");
        load_image("bad", 1'b0, 8'h98);
        check_status("bad_end", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("bad_no_more_wr", 32'(wa.size()), 32'd2);
        check_status("bad_stuck", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset("r3");
        send_byte(8'h00, 1'b0);
        send_byte(8'h39, 1'b0);
        check_status("over", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("over_nwrites", 32'(wa.size()), 32'd0);

        do_reset("r4");
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        bus.byte_valid = 1'b0;
        repeat (999) @(negedge clk);
        chk("tmo_not_yet", 32'(bus.error), 32'd0);
        chk("tmo_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_status("tmo", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tmo_nwrites", 32'(wa.size()), 32'd0);

        do_reset("r5");
        load_image("post", 1'b0, 8'h99);
        check_status("post_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        do_reset("r6");
        low_cnt = 0;
        load_image("thr", 1'b1, 8'h99);
        check_status("thr_end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("thr_ready_low_cycles", 32'(low_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
